// File: rtl/alu_pkg.sv
// Shared encodings for the 65C02 ALU stage: opcodes, carry-in select,
// status bit positions and the FSM state type.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ORA  = 4'h0,
    OP_AND  = 4'h1,
    OP_EOR  = 4'h2,
    OP_ADC  = 4'h3,
    OP_SBC  = 4'h4,
    OP_CMP  = 4'h5,
    OP_ASL  = 4'h6,
    OP_LSR  = 4'h7,
    OP_ROL  = 4'h8,
    OP_ROR  = 4'h9,
    OP_BIT  = 4'hA,
    OP_TRB  = 4'hB,
    OP_TSB  = 4'hC,
    OP_PASR = 4'hD,
    OP_PASM = 4'hE,
    OP_RSV  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    CI_ZERO  = 2'd0,
    CI_ONE   = 2'd1,
    CI_PC    = 2'd2,
    CI_ZERO3 = 2'd3
  } ci_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DADJ = 1'b1
  } state_e;

  localparam int unsigned P_N = 7;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_C = 0;

  localparam logic [7:0] P_RESET = 8'h34;
  localparam logic [7:0] P_FORCE = 8'h30;

endpackage

// File: rtl/alu_dec.sv
// Combinational BCD correction applied to a registered binary ADC/SBC sum.
module alu_dec (
  input  logic [7:0] sum_i,
  input  logic       hc_i,
  input  logic       c_i,
  input  logic       sub_i,
  output logic [7:0] adj_o,
  output logic       dc_o
);

  logic       lo_fix;
  logic       hi_fix;
  logic [8:0] t;

  always_comb begin
    lo_fix = 1'b0;
    hi_fix = 1'b0;
    t      = {1'b0, sum_i};
    adj_o  = sum_i;
    dc_o   = c_i;
    if (sub_i) begin
      // Nibble borrows are the inverted carries of the binary stage.
      adj_o = sum_i - (hc_i ? 8'h00 : 8'h06) - (c_i ? 8'h00 : 8'h60);
      dc_o  = c_i;
    end else begin
      lo_fix = hc_i || (sum_i[3:0] > 4'd9);
      t      = {1'b0, sum_i} + (lo_fix ? 9'h006 : 9'h000);
      hi_fix = c_i || t[8] || (t[7:4] > 4'd9);
      adj_o  = t[7:0] + (hi_fix ? 8'h60 : 8'h00);
      dc_o   = hi_fix;
    end
  end

endmodule

// File: rtl/alu.sv
// 65C02 ALU stage: registered result OUT, status register P, and the extra
// decimal-adjust cycle for ADC/SBC with P.D set.
module alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] R,
  input  logic [7:0] M,
  input  logic       valid,
  input  logic [3:0] alu_op,
  input  logic       sh_m,
  input  logic [1:0] ci_sel,
  input  logic       upd_nz,
  input  logic       upd_v,
  input  logic       upd_c,
  input  logic       p_we,
  output logic [7:0] OUT,
  output logic [7:0] P,
  output logic       ready
);

  alu_op_e    op;
  state_e     state_q, state_d;
  logic [7:0] out_q, out_d;
  logic [7:0] p_q, p_d;

  logic [7:0] dsum_q;
  logic       dh_q, dc_q, dsub_q, dv_q;
  logic       dnz_q, dupdv_q, dupdc_q;

  logic       ci, cin, is_sub, hc, bin_v, dec_start;
  logic [7:0] opnd, shin, res;
  logic [8:0] sum9;
  logic       n_new, z_new, v_new, c_new;
  logic [7:0] dec_adj;
  logic       dec_c;

  assign op = alu_op_e'(alu_op);

  always_comb begin
    case (ci_sel_e'(ci_sel))
      CI_ONE:  ci = 1'b1;
      CI_PC:   ci = p_q[P_C];
      default: ci = 1'b0;
    endcase
    is_sub = (op == OP_SBC) || (op == OP_CMP);
    opnd   = is_sub ? ~M : M;
    cin    = (op == OP_CMP) ? 1'b1 : ci;
    sum9   = {1'b0, R} + {1'b0, opnd} + {8'h00, cin};
    hc     = R[4] ^ opnd[4] ^ sum9[4];
    bin_v  = (R[7] == opnd[7]) && (sum9[7] != R[7]);
    shin   = sh_m ? M : R;
    dec_start = valid && ((op == OP_ADC) || (op == OP_SBC)) && p_q[P_D];

    res   = R;
    c_new = p_q[P_C];
    v_new = p_q[P_V];
    case (op)
      OP_ORA, OP_TSB: res = R | M;
      OP_AND, OP_BIT: res = R & M;
      OP_EOR:         res = R ^ M;
      OP_TRB:         res = ~R & M;
      OP_ADC, OP_SBC, OP_CMP: begin
        res   = sum9[7:0];
        c_new = sum9[8];
        v_new = bin_v;
      end
      OP_ASL: begin res = {shin[6:0], 1'b0}; c_new = shin[7]; end
      OP_ROL: begin res = {shin[6:0], ci};   c_new = shin[7]; end
      OP_LSR: begin res = {1'b0, shin[7:1]}; c_new = shin[0]; end
      OP_ROR: begin res = {ci, shin[7:1]};   c_new = shin[0]; end
      OP_PASM: res = M;
      default: res = R;
    endcase

    n_new = res[7];
    z_new = (res == 8'h00);
    if ((op == OP_BIT) || (op == OP_TSB) || (op == OP_TRB)) z_new = ((R & M) == 8'h00);
    if (op == OP_BIT) begin
      n_new = M[7];
      v_new = M[6];
    end
  end

  alu_dec u_dec (
    .sum_i (dsum_q),
    .hc_i  (dh_q),
    .c_i   (dc_q),
    .sub_i (dsub_q),
    .adj_o (dec_adj),
    .dc_o  (dec_c)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (dec_start) begin
          state_d = ST_DADJ;
        end else if (valid) begin
          out_d = res;
          if (upd_nz) begin
            p_d[P_N] = n_new;
            p_d[P_Z] = z_new;
          end
          if (upd_v) p_d[P_V] = v_new;
          if (upd_c) p_d[P_C] = c_new;
        end
        if (p_we) p_d = M;
      end
      ST_DADJ: begin
        // Flag enables were captured with the binary stage; live inputs are ignored here.
        state_d = ST_IDLE;
        out_d   = dec_adj;
        if (dnz_q) begin
          p_d[P_N] = dec_adj[7];
          p_d[P_Z] = (dec_adj == 8'h00);
        end
        if (dupdv_q) p_d[P_V] = dv_q;
        if (dupdc_q) p_d[P_C] = dec_c;
      end
      default: state_d = ST_IDLE;
    endcase
    p_d = p_d | P_FORCE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      p_q     <= P_RESET;
      dsum_q  <= '0;
      dh_q    <= 1'b0;
      dc_q    <= 1'b0;
      dsub_q  <= 1'b0;
      dv_q    <= 1'b0;
      dnz_q   <= 1'b0;
      dupdv_q <= 1'b0;
      dupdc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      p_q     <= p_d;
      if ((state_q == ST_IDLE) && dec_start) begin
        dsum_q  <= sum9[7:0];
        dh_q    <= hc;
        dc_q    <= sum9[8];
        dsub_q  <= (op == OP_SBC);
        dv_q    <= bin_v;
        dnz_q   <= upd_nz;
        dupdv_q <= upd_v;
        dupdc_q <= upd_c;
      end
    end
  end

  assign OUT   = out_q;
  assign P     = p_q;
  assign ready = (state_q == ST_IDLE);

endmodule
